// File: rtl/cdt_pkg.sv
// cdt_pkg: shared constants for the 256-bit demux datapath (loader and demux bank).
//   CDT_NWORDS  words per 256-bit entry
//   CDT_SLOT_W  slot index width (16 demux outputs)
//   CDT_WORD_W  staging word width
//   ST_*        loader FSM state encoding
package cdt_pkg;

   localparam int unsigned CDT_NWORDS = 8;
   localparam int unsigned CDT_SLOT_W = 4;
   localparam int unsigned CDT_WORD_W = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [1:0] ST_ABORT  = 2'd3;

endpackage

// File: rtl/cdt_wdog_cnt.sv
// cdt_wdog_cnt: clearable, saturating idle counter with a terminal-count flag.
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   clr  in   synchronous clear (priority over en)
//   en   in   count one idle cycle
//   tc   out  counter has reached TIMEOUT-1
module cdt_wdog_cnt #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned W = $clog2(TIMEOUT);
   localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != TC_VAL)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/cdt_bus256_loader.sv
// cdt_bus256_loader: gathers a 32-bit word stream into eight staging registers
// and issues a one-cycle commit strobe (en) with slot index (sw) so the demux
// bank latches {reg7..reg0}. Multi-slot bursts auto-increment sw; a watchdog
// aborts a stalled fill without committing.
//   clk, rst           clock, asynchronous active-high reset
//   start, slot        begin a burst at slot (sampled in IDLE only)
//   nslots             burst length; 0 -> 1, >16 -> 16
//   wr_valid, wr_data  word stream; accepted when wr_valid & wr_ready
//   wr_ready           high only while filling
//   reg0..reg7         staging registers to the demux
//   en, sw             commit strobe and target slot
//   busy               not idle
//   done               pulse with the final en of a burst
//   err                pulse on watchdog abort
module cdt_bus256_loader
   import cdt_pkg::*;
#(
   parameter int unsigned NWORDS  = CDT_NWORDS,
   parameter int unsigned WORD_W  = CDT_WORD_W,
   parameter int unsigned SLOT_W  = CDT_SLOT_W,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SLOT_W-1:0] slot,
   input  logic [SLOT_W:0]   nslots,
   input  logic              wr_valid,
   input  logic [WORD_W-1:0] wr_data,
   output logic              wr_ready,
   output logic [WORD_W-1:0] reg0,
   output logic [WORD_W-1:0] reg1,
   output logic [WORD_W-1:0] reg2,
   output logic [WORD_W-1:0] reg3,
   output logic [WORD_W-1:0] reg4,
   output logic [WORD_W-1:0] reg5,
   output logic [WORD_W-1:0] reg6,
   output logic [WORD_W-1:0] reg7,
   output logic              en,
   output logic [SLOT_W-1:0] sw,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned WCW = $clog2(NWORDS);
   localparam logic [WCW-1:0]  WLAST = WCW'(NWORDS - 1);
   localparam logic [SLOT_W:0] BMAX  = (SLOT_W + 1)'(2 ** SLOT_W);
   localparam logic [SLOT_W:0] BONE  = (SLOT_W + 1)'(1);

   logic [1:0]        state;
   logic [WCW-1:0]    wcnt;
   logic [SLOT_W:0]   bcnt;
   logic [WORD_W-1:0] stage [NWORDS];
   logic              hs;
   logic              wd_clr;
   logic              wd_en;
   logic              wd_tc;
   logic [SLOT_W:0]   nslots_c;

   assign hs = wr_valid & wr_ready;

   // Watchdog only runs in FILL; any accepted word or leaving FILL restarts it.
   assign wd_clr = (state != ST_FILL) | hs;
   assign wd_en  = (state == ST_FILL) & ~hs;

   always_comb begin
      nslots_c = nslots;
      if (nslots == '0) begin
         nslots_c = BONE;
      end else if (nslots > BMAX) begin
         nslots_c = BMAX;
      end
   end

   cdt_wdog_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr),
      .en  (wd_en),
      .tc  (wd_tc)
   );

   // All outputs are registered: en/done/err/wr_ready are set on the edge
   // that enters the state they belong to, so they line up with that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wcnt     <= '0;
         bcnt     <= '0;
         sw       <= '0;
         wr_ready <= 1'b0;
         busy     <= 1'b0;
         en       <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         for (int unsigned i = 0; i < NWORDS; i++) begin
            stage[i] <= '0;
         end
      end else begin
         en   <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sw       <= slot;
                  bcnt     <= nslots_c;
                  wcnt     <= '0;
                  wr_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (hs) begin
                  stage[wcnt] <= wr_data;
                  if (wcnt == WLAST) begin
                     wr_ready <= 1'b0;
                     en       <= 1'b1;
                     done     <= (bcnt == BONE);
                     state    <= ST_COMMIT;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end else if (wd_tc) begin
                  wr_ready <= 1'b0;
                  err      <= 1'b1;
                  state    <= ST_ABORT;
               end
            end
            ST_COMMIT: begin
               bcnt <= bcnt - 1'b1;
               wcnt <= '0;
               if (bcnt > BONE) begin
                  sw       <= sw + 1'b1;
                  wr_ready <= 1'b1;
                  state    <= ST_FILL;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               // ST_ABORT: partial staging contents are kept, burst dropped.
               bcnt  <= '0;
               wcnt  <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign reg0 = stage[0];
   assign reg1 = stage[1];
   assign reg2 = stage[2];
   assign reg3 = stage[3];
   assign reg4 = stage[4];
   assign reg5 = stage[5];
   assign reg6 = stage[6];
   assign reg7 = stage[7];

endmodule
